// File: rtl/stuck_at_bist_engine.sv
// Stuck-at BIST engine: counter/LFSR pattern source, optional single-bit stuck-at
// injection on the pattern, MISR compaction of the CUT response, golden compare.
module stuck_at_bist_engine #(
  parameter int                   WIDTH     = 3,
  parameter int                   OUT_WIDTH = 3,
  parameter int                   CNT_W     = 8,
  parameter logic [WIDTH-1:0]     LFSR_POLY = 3'b011,
  parameter logic [WIDTH-1:0]     LFSR_SEED = 3'b001,
  parameter logic [OUT_WIDTH-1:0] MISR_POLY = 3'b011,
  parameter logic [OUT_WIDTH-1:0] MISR_SEED = 3'b000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     mode_i,
  input  logic [CNT_W-1:0]         num_pat_i,
  input  logic [OUT_WIDTH-1:0]     golden_i,
  input  logic                     fault_en_i,
  input  logic [$clog2(WIDTH)-1:0] fault_sel_i,
  input  logic                     fault_val_i,
  output logic [WIDTH-1:0]         pat_o,
  input  logic [OUT_WIDTH-1:0]     resp_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [OUT_WIDTH-1:0]     sig_o
);

  localparam int SEL_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  logic                 r_mode;
  logic [CNT_W-1:0]     r_num_pat;
  logic [OUT_WIDTH-1:0] r_golden;
  logic                 r_fault_en;
  logic [SEL_W-1:0]     r_fault_sel;
  logic                 r_fault_val;
  logic [WIDTH-1:0]     r_pat;
  logic [OUT_WIDTH-1:0] r_misr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_pass;

  logic [WIDTH-1:0]     w_lfsr_next;
  logic [WIDTH-1:0]     w_pat_next;
  logic [WIDTH-1:0]     w_pat_applied;
  logic [OUT_WIDTH-1:0] w_misr_next;
  logic                 w_last;

  always_comb begin
    w_lfsr_next = {r_pat[WIDTH-2:0], 1'b0} ^ (r_pat[WIDTH-1] ? LFSR_POLY : '0);
    w_pat_next  = r_mode ? w_lfsr_next : r_pat + 1'b1;
    w_misr_next = {r_misr[OUT_WIDTH-2:0], 1'b0}
                ^ (r_misr[OUT_WIDTH-1] ? MISR_POLY : '0) ^ resp_i;
    w_last      = (r_cnt == r_num_pat - 1'b1);
  end

  // Fault is applied on the way out so the generator sequence itself is never disturbed.
  always_comb begin
    w_pat_applied = r_pat;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_fault_en && (r_fault_sel == SEL_W'(i))) begin
        w_pat_applied[i] = r_fault_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_num_pat   <= '0;
      r_golden    <= '0;
      r_fault_en  <= 1'b0;
      r_fault_sel <= '0;
      r_fault_val <= 1'b0;
      r_pat       <= '0;
      r_misr      <= '0;
      r_cnt       <= '0;
      r_pass      <= 1'b0;
    end else if (abort_i) begin
      r_state <= S_IDLE;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_mode      <= mode_i;
            r_num_pat   <= num_pat_i;
            r_golden    <= golden_i;
            r_fault_en  <= fault_en_i;
            r_fault_sel <= fault_sel_i;
            r_fault_val <= fault_val_i;
            r_pat       <= mode_i ? LFSR_SEED : '0;
            r_misr      <= MISR_SEED;
            r_cnt       <= '0;
            if (num_pat_i == '0) begin
              r_state <= S_DONE;
              r_pass  <= (MISR_SEED == golden_i);
            end else begin
              r_state <= S_RUN;
              r_pass  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_misr <= w_misr_next;
          r_pat  <= w_pat_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_pass  <= (w_misr_next == r_golden);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pat_o  = (r_state == S_RUN) ? w_pat_applied : '0;
  assign busy_o = (r_state == S_RUN);
  assign done_o = (r_state == S_DONE);
  assign pass_o = r_pass;
  assign sig_o  = r_misr;

endmodule

// File: tb/tb_stuck_at_bist_engine.sv
// Bench for stuck_at_bist_engine: directed steps plus randomized runs against a
// GF(2)-polynomial reference model of the pattern source and signature.
module tb_stuck_at_bist_engine;

  localparam int W     = 3;
  localparam int OW    = 3;
  localparam int LPOLY = 3;
  localparam int LSEED = 1;
  localparam int MPOLY = 3;
  localparam int MSEED = 0;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic          abort_i;
  logic          mode_i;
  logic [7:0]    num_pat_i;
  logic [OW-1:0] golden_i;
  logic          fault_en_i;
  logic [1:0]    fault_sel_i;
  logic          fault_val_i;
  logic [W-1:0]  pat_o;
  logic [OW-1:0] resp_i;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic [OW-1:0] sig_o;

  logic          resp_cut;
  logic [OW-1:0] resp_const;

  int checks = 0;
  int errors = 0;
  int exp_pat [0:63];
  int exp_sig [0:64];
  int obs_q[$];
  int lfsr_ref [0:7] = '{1, 2, 4, 3, 6, 7, 5, 1};

  stuck_at_bist_engine dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .mode_i(mode_i), .num_pat_i(num_pat_i), .golden_i(golden_i),
    .fault_en_i(fault_en_i), .fault_sel_i(fault_sel_i), .fault_val_i(fault_val_i),
    .pat_o(pat_o), .resp_i(resp_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .sig_o(sig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in combinational circuit under test.
  function automatic logic [OW-1:0] cut_fn(input logic [W-1:0] p);
    return {p[0] & p[1], p[1] ^ p[2], p[0] | ~p[2]};
  endfunction

  assign resp_i = resp_cut ? cut_fn(pat_o) : resp_const;

  // Multiply by x modulo (x^w + poly) over GF(2).
  function automatic int mulx(input int v, input int w, input int poly);
    int r;
    r = v * 2;
    if (r >= (1 << w)) r = (r - (1 << w)) ^ poly;
    return r;
  endfunction

  task automatic model(input bit mode, input int n, input bit fen, input int fsel,
                       input bit fval, input bit rcut, input int rconst);
    int p;
    int s;
    int raw;
    int app;
    int r;
    p = LSEED;
    s = MSEED;
    for (int k = 0; k < n; k++) begin
      raw = mode ? p : (k % (1 << W));
      app = raw;
      if (fen) app = fval ? (raw | (1 << fsel)) : (raw & ~(1 << fsel));
      exp_pat[k] = app;
      exp_sig[k] = s;
      r = rcut ? int'(cut_fn(W'(app))) : rconst;
      s = mulx(s, OW, MPOLY) ^ r;
      p = mulx(p, W, LPOLY);
    end
    exp_sig[n] = s;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; ends at posedge+1 just after the run reaches DONE.
  task automatic run_test(input bit mode, input int n, input int gold, input bit gold_model,
                          input bit fen, input int fsel, input bit fval,
                          input bit rcut, input int rconst, input bit scramble);
    int g;
    model(mode, n, fen, fsel, fval, rcut, rconst);
    g = gold_model ? exp_sig[n] : gold;
    resp_cut    = rcut;
    resp_const  = OW'(rconst);
    mode_i      = mode;
    num_pat_i   = 8'(n);
    golden_i    = OW'(g);
    fault_en_i  = fen;
    fault_sel_i = 2'(fsel);
    fault_val_i = fval;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    obs_q.delete();
    for (int k = 0; k < n; k++) begin
      chk("pat", 32'(pat_o), 32'(exp_pat[k]));
      chk("busy_run", 32'(busy_o), 32'd1);
      chk("sig_run", 32'(sig_o), 32'(exp_sig[k]));
      obs_q.push_back(int'(pat_o));
      if (scramble) begin
        mode_i      = 1'($urandom);
        num_pat_i   = 8'($urandom);
        golden_i    = OW'($urandom);
        fault_en_i  = 1'($urandom);
        fault_sel_i = 2'($urandom_range(0, 2));
        fault_val_i = 1'($urandom);
        start_i     = 1'($urandom);
      end
      tick();
      start_i = 1'b0;
    end
    chk("done", 32'(done_o), 32'd1);
    chk("busy_end", 32'(busy_o), 32'd0);
    chk("pat_idle", 32'(pat_o), 32'd0);
    chk("sig_final", 32'(sig_o), 32'(exp_sig[n]));
    chk("pass", 32'(pass_o), 32'(exp_sig[n] == g));
  endtask

  initial begin
    rst_n       = 1'b0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    mode_i      = 1'b0;
    num_pat_i   = '0;
    golden_i    = '0;
    fault_en_i  = 1'b0;
    fault_sel_i = '0;
    fault_val_i = 1'b0;
    resp_cut    = 1'b0;
    resp_const  = '0;

    repeat (2) tick();
    chk("rst_pat", 32'(pat_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_pass", 32'(pass_o), 32'd0);
    chk("rst_sig", 32'(sig_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // LFSR sequence, response tied low, golden 0.
    run_test(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) chk("lfsr_seq", 32'(obs_q[i]), 32'(lfsr_ref[i]));

    // Counter wrap with N above the period.
    run_test(0, 10, 5, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) chk("cnt_wrap", 32'(obs_q[i]), 32'(i % 8));

    // MISR arithmetic: constant response 001, matching and mismatching golden.
    run_test(0, 2, 3, 0, 0, 0, 0, 0, 1, 0);
    chk("misr_lit", 32'(sig_o), 32'd3);
    run_test(0, 2, 2, 0, 0, 0, 0, 0, 1, 0);
    chk("misr_fail_pass", 32'(pass_o), 32'd0);

    // Fault injection; latched inputs scrambled during the run.
    run_test(0, 4, 0, 1, 1, 0, 1, 1, 0, 1);
    chk("fault_p0", 32'(obs_q[0]), 32'd1);
    chk("fault_p3", 32'(obs_q[3]), 32'd3);

    // N = 0: immediate DONE with pass against the seed.
    run_test(0, 0, MSEED, 0, 0, 0, 0, 1, 0, 0);
    chk("n0_pass", 32'(pass_o), 32'd1);

    // Abort out of DONE clears done/pass but keeps the signature.
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_done_done", 32'(done_o), 32'd0);
    chk("abort_done_pass", 32'(pass_o), 32'd0);
    chk("abort_done_sig", 32'(sig_o), 32'(MSEED));

    // Abort in the third cycle of an 8-pattern run.
    model(0, 8, 0, 0, 0, 1, 0);
    resp_cut = 1'b1; mode_i = 1'b0; num_pat_i = 8'd8; fault_en_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    chk("abort_pre_sig", 32'(sig_o), 32'(exp_sig[2]));
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_pat", 32'(pat_o), 32'd0);
    chk("abort_sig_hold", 32'(sig_o), 32'(exp_sig[2]));

    // Simultaneous start and abort stays idle.
    start_i = 1'b1; abort_i = 1'b1; num_pat_i = 8'd4;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    chk("start_abort_busy", 32'(busy_o), 32'd0);
    chk("start_abort_done", 32'(done_o), 32'd0);
    tick();
    chk("start_abort_busy2", 32'(busy_o), 32'd0);

    // New run after abort completes normally.
    run_test(1, 6, 0, 1, 0, 0, 0, 1, 0, 0);

    // Asynchronous reset in the middle of a run.
    mode_i = 1'b1; num_pat_i = 8'd8; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    chk("mid_busy", 32'(busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pat", 32'(pat_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_pass", 32'(pass_o), 32'd0);
    chk("arst_sig", 32'(sig_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized runs.
    for (int it = 0; it < 25; it++) begin
      run_test(1'($urandom), $urandom_range(0, 40), $urandom_range(0, 7), 1'($urandom),
               1'($urandom), $urandom_range(0, 2), 1'($urandom),
               1'($urandom_range(0, 3) != 0), $urandom_range(0, 7), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stuck_at_bist_engine.md
# stuck_at_bist_engine

- Parametrised built-in self-test engine for the combinational stuck-at test circuits in this codebase.
- Generates patterns (exhaustive counter or Galois LFSR) and drives them onto an external circuit-under-test (CUT).
- Compacts the CUT response into a MISR signature and compares it with a golden signature.
- Optionally injects a stuck-at-0/1 fault on one selected pattern bit, so a fault's detectability is measured on silicon/sim.

## Interface
- WIDTH, 3: pattern width (CUT inputs); ≥2.
- OUT_WIDTH, 3: response/signature width (CUT outputs); ≥2.
- CNT_W, 8: pattern-count width.
- LFSR_POLY, 3'b011: Galois LFSR feedback taps (WIDTH bits).
- LFSR_SEED, 3'b001: LFSR start value; nonzero.
- MISR_POLY, 3'b011: MISR feedback taps (OUT_WIDTH bits).
- MISR_SEED, 3'b000: MISR start value.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  start pulse; honoured in IDLE and DONE.
- abort_i  in  1  synchronous abort; priority over start_i.
- mode_i  in  1  0 = exhaustive counter, 1 = LFSR.
- num_pat_i  in  CNT_W  patterns to apply.
- golden_i  in  OUT_WIDTH  expected signature.
- fault_en_i  in  1  enable stuck-at injection.
- fault_sel_i  in  $clog2(WIDTH)  pattern bit to force.
- fault_val_i  in  1  stuck value.
- pat_o  out  WIDTH  pattern to CUT.
- resp_i  in  OUT_WIDTH  CUT response; combinational from pat_o.
- busy_o  out  1  high in RUN.
- done_o  out  1  high in DONE.
- pass_o  out  1  signature matched golden; valid when done_o is high.
- sig_o  out  OUT_WIDTH  current MISR value.

## Operation

States: IDLE, RUN, DONE.

- **Reset:** all outputs are 0 (including sig_o = 0, and pass_o = 0).
- **Start** (IDLE or DONE):
  - Latch mode_i, num_pat_i, golden_i, fault_en_i, fault_sel_i and fault_val_i.
  - Load pattern register: 0 in counter mode, LFSR_SEED in LFSR mode.
  - Load misr = MISR_SEED and cnt = 0.
  - If latched num_pat = 0: go to DONE, with pass = (MISR_SEED == golden). Otherwise go to RUN.
- **RUN, each edge:**
  - misr ← {misr[OUT_WIDTH-2:0],0} ^ (misr[MSB] ? MISR_POLY : 0) ^ resp_i.
  - Pattern advances: counter mode +1 modulo 2^WIDTH; LFSR mode {p[WIDTH-2:0],0} ^ (p[MSB] ? LFSR_POLY : 0).
  - cnt increments.
  - When cnt == num_pat-1, go to DONE and register pass = (new misr == golden).
- **pat_o:**
  - In RUN: the pattern register with the fault applied. If fault_en, bit fault_sel is replaced by fault_val.
  - Outside RUN: pat_o = 0.
- **Wrap-around:** num_pat above the generator period repeats patterns (counter period 2^WIDTH, LFSR period ≤ 2^WIDTH-1). This is not an error.
- **abort_i:** in any state, go to IDLE on the next edge. done_o and pass_o clear; sig_o holds.
- **Input stability:** changes to latched inputs during RUN have no effect.
- **Reset mid-RUN:** immediate return to the reset values.

## Timing
- Start sampled at edge E0 → pattern k is on pat_o between edges E(k) and E(k+1), for k = 0..N-1.
- Response to pattern k is captured at edge E(k+1).
- done_o rises after edge EN, i.e. N cycles after the start edge. busy_o is high for exactly N cycles.
- num_pat = 0 → done_o is high after E0, busy_o never asserts.
- start_i and abort_i in the same cycle → abort wins.
- start_i while in RUN is ignored.

## Test plan
- **LFSR sequence:** Defaults, mode 1, N = 8, resp_i tied 0, golden 0. Required pat_o sequence: 001, 010, 100, 011, 110, 111, 101, 001. Then done after 8 cycles, sig_o = 000, pass_o = 1.
- **Counter mode with wrap:** mode 0, N = 10. Required pat_o sequence: 0..7, then 0, 1. busy_o is high for exactly 10 cycles.
- **MISR arithmetic:** mode 0, N = 2, resp_i = 001 both cycles, golden 011. Required: sig after pattern 0 = 001, final 011, pass_o = 1. Repeat with golden 010 → pass_o = 0.
- **Fault injection:** fault_en = 1, sel = 0, val = 1, mode 0, N = 4. Required pat_o: 001, 001, 011, 011. Injection turned off mid-run has no effect.
- **N = 0 edge case:** N = 0, golden = MISR_SEED. Required: done_o and pass_o high one cycle after start, busy_o never high.
- **Abort and reset:** abort in cycle 3 of an N = 8 run → IDLE next edge, done_o = 0, sig_o held. Simultaneous start + abort → IDLE. rst_n low mid-RUN → all outputs 0 asynchronously. A new start after abort completes normally.
